reset_domain_sequencer: RTL and testbench
=========================================

// Module: reset_domain_sequencer
// PURPOSE
//  Orders the release and re-assertion of N downstream reset/enable domains. Each domain
//  bit is held in a per-bit async-reset register vector; this block decides when each bit
//  is written. Domains release in ascending order (0 first) and re-assert in descending
//  order, with a programmable gap between steps. Sits between the power/clock controller
//  (req/ack) and the domain register vectors.
// PARAMETERS
//  N_DOM     2   number of sequenced domains (1..8)
//  CNT_W     8   width of the inter-step delay counter
//  DLY_RST   16  delay value loaded into cfg register at reset (cycles)
// PORTS
//  clock        in   1      sole clock
//  reset_n      in   1      asynchronous, active-low reset
//  req_on       in   1      level: 1 = domains should be up, 0 = down
//  ack          out  1      level: equals req_on once the sequence for that level completes
//  busy         out  1      1 while a release/assert sequence is in progress
//  cfg_we       in   1      write strobe for delay register
//  cfg_dly      in   CNT_W  new delay value (cycles between steps)
//  dom_rst_n    out  N_DOM  per-domain reset, active-low, to the async-reset reg vector
//  step_idx     out  3      index of domain currently being waited on (debug)
// BEHAVIOUR
//  Reset values: dom_rst_n=0 (all domains held), ack=0, busy=0, step_idx=0, dly_q=DLY_RST.
//  All outputs registered; asserting reset_n low returns them to these values immediately.
//  FSM: DOWN -> REL_WAIT -> UP -> AST_WAIT -> DOWN.
//   DOWN: req_on=1 -> load cnt=dly_q, step_idx=0, busy=1, go REL_WAIT.
//   REL_WAIT: cnt decrements each cycle; at cnt==0 set dom_rst_n[step_idx]=1. If step_idx==
//    N_DOM-1 go UP (ack=1, busy=0) next cycle; else step_idx++, cnt reloads dly_q.
//   UP: req_on=0 -> step_idx=N_DOM-1, cnt=dly_q, busy=1, go AST_WAIT.
//   AST_WAIT: at cnt==0 clear dom_rst_n[step_idx]; at step_idx==0 go DOWN (ack=0, busy=0).
//  Latency: domain k releases (k+1)*(dly_q+1) cycles after req_on rises in DOWN; ack rises
//   one cycle after the last domain's bit is set. dly_q=0 gives one step per cycle.
//  Reversal mid-sequence: req_on falling in REL_WAIT switches to AST_WAIT without touching
//   already-released bits: step_idx stays on the highest released domain (or exits to DOWN
//   if none released), cnt reloads. Symmetric for req_on rising in AST_WAIT -> REL_WAIT
//   starting at the lowest held domain. ack never toggles during a reversal.
//  Invariant: dom_rst_n is always a thermometer code (bits 0..k set, rest clear).
//  cfg_we: dly_q updates any cycle; an active countdown keeps its loaded value, new value
//   applies at the next reload. Simultaneous cfg_we and reload: reload uses new cfg_dly.
//  Counter never wraps: holds at 0 until the FSM reloads it.
//  N_DOM=1: REL_WAIT/AST_WAIT run a single step.
// STRUCTURE
//  Shared package rst_seq_pkg: state enum (DOWN, REL_WAIT, UP, AST_WAIT), STEP_W=3.
//  One sub-module: rst_seq_delay_cnt (load, dec, zero flag, CNT_W wide). FSM, step index
//  and dom_rst_n register stay in the top module.
// TESTING
//  1 Reset, dly_q=16, N_DOM=2, req_on 0->1 -> dom_rst_n 00->01 at +17, 11 at +34; ack at +35.
//  2 From UP, req_on 1->0 -> dom_rst_n 11->01 at +17, 00 at +34; ack falls at +35.
//  3 req_on falls 5 cycles after domain 0 released -> bit0 clears 17 cycles later, bit1
//    never sets, ack stays 0, busy falls with bit0.
//  4 cfg_dly=0 via cfg_we before req_on -> one domain per cycle; cfg_we=3 mid-countdown
//    -> current step unchanged, next step takes 4 cycles.
//  5 reset_n low while UP -> dom_rst_n=00, ack=0, busy=0 same cycle, dly_q back to 16.
//  6 Random req_on toggling 2000 cycles -> dom_rst_n always thermometer, ack==req_on
//    whenever busy=0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared definitions for the reset domain sequencer: the sequencer state
//   encoding and the width of the step index that is exported for debug.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

  // Width of the step index; wide enough to address up to eight domains.
  localparam int STEP_W = 3;

  // DOWN / UP are the settled states. The two *_WAIT states walk the domains
  // one at a time: REL_WAIT releases in ascending order, AST_WAIT re-asserts
  // in descending order.
  typedef enum logic [1:0] {
    ST_DOWN     = 2'd0,
    ST_REL_WAIT = 2'd1,
    ST_UP       = 2'd2,
    ST_AST_WAIT = 2'd3
  } seq_state_e;

endpackage : rst_seq_pkg

// File: rtl/rst_seq_delay_cnt.sv
// -----------------------------------------------------------------------------
// rst_seq_delay_cnt
//   Inter-step delay counter. Loads a value, counts down once per cycle while
//   enabled, and holds at zero (never wraps) until it is loaded again.
//
// Ports
//   clock       in   1      clock
//   reset_n     in   1      asynchronous active-low reset (count clears to 0)
//   load_i      in   1      load load_val_i this cycle (wins over dec_i)
//   load_val_i  in   CNT_W  value to load
//   dec_i       in   1      decrement enable
//   zero_o      out  1      count is zero
// -----------------------------------------------------------------------------
module rst_seq_delay_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : rst_seq_delay_cnt

// File: rtl/reset_domain_sequencer.sv
// -----------------------------------------------------------------------------
// reset_domain_sequencer
//   Orders release and re-assertion of N_DOM downstream reset domains. On a
//   rising req_on the domains are released in ascending order, on a falling
//   req_on they are re-asserted in descending order, with dly_q+1 cycles
//   between steps. ack follows req_on once the sequence for that level has
//   completed; a reversal mid-sequence turns around from the current position
//   without disturbing domains already released (or held).
//
// Ports
//   clock      in   1      clock
//   reset_n    in   1      asynchronous active-low reset
//   req_on     in   1      requested level: 1 = domains up, 0 = domains down
//   ack        out  1      settled level, equals req_on after completion
//   busy       out  1      a release/assert sequence is in progress
//   cfg_we     in   1      write strobe for the delay register
//   cfg_dly    in   CNT_W  new inter-step delay (cycles)
//   dom_rst_n  out  N_DOM  per-domain active-low reset, thermometer coded
//   step_idx   out  3      domain currently being waited on (debug)
// -----------------------------------------------------------------------------
module reset_domain_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOM   = 2,
  parameter int CNT_W   = 8,
  parameter int DLY_RST = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_on,
  output logic              ack,
  output logic              busy,
  input  logic              cfg_we,
  input  logic [CNT_W-1:0]  cfg_dly,
  output logic [N_DOM-1:0]  dom_rst_n,
  output logic [STEP_W-1:0] step_idx
);

  localparam logic [CNT_W-1:0]  DLY_RST_V = CNT_W'(DLY_RST);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_DOM - 1);
  localparam logic [N_DOM-1:0]  ALL_UP    = {N_DOM{1'b1}};

  seq_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_q,  step_d;
  logic [N_DOM-1:0]  dom_q,   dom_d;
  logic              ack_q,   ack_d;
  logic              busy_q,  busy_d;
  logic [CNT_W-1:0]  dly_q,   dly_d;

  logic [N_DOM-1:0]  step_mask;
  logic              step_released;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_dec;
  logic              cnt_zero;

  // A write in the same cycle as a reload takes effect for that reload.
  assign dly_d        = cfg_we ? cfg_dly : dly_q;
  assign cnt_load_val = dly_d;

  // One-hot select of the current domain; avoids indexing the domain vector
  // with a step index that may be wider than needed.
  assign step_mask     = N_DOM'(1) << step_q;
  assign step_released = (dom_q & step_mask) != '0;

  assign cnt_dec = (state_q == ST_REL_WAIT) || (state_q == ST_AST_WAIT);

  rst_seq_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Completion is split in two cases: if ack already shows the target level
  // (the sequence is a reversal back to where ack stands) the FSM settles on
  // the same edge as the last domain step; otherwise it waits one more cycle
  // so ack changes together with busy falling. This keeps ack == req_on
  // whenever busy is low, and ack never moves during a reversal.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dom_d    = dom_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    cnt_load = 1'b0;

    unique case (state_q)
      ST_DOWN: begin
        if (req_on) begin
          state_d  = ST_REL_WAIT;
          step_d   = '0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end

      ST_REL_WAIT: begin
        if (!req_on) begin
          if ((dom_q == '0) && !ack_q) begin
            // Nothing released yet: turn straight back to DOWN.
            state_d = ST_DOWN;
            busy_d  = 1'b0;
          end else begin
            // Re-assert from the highest released domain downward.
            state_d  = ST_AST_WAIT;
            cnt_load = 1'b1;
            if (step_released) begin
              step_d = step_q;
            end else if (step_q != '0) begin
              step_d = step_q - STEP_W'(1);
            end else begin
              step_d = '0;
            end
          end
        end else if (dom_q == ALL_UP) begin
          state_d = ST_UP;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_zero) begin
          dom_d = dom_q | step_mask;
          if (step_q == LAST_STEP) begin
            if (ack_q) begin
              state_d = ST_UP;
              busy_d  = 1'b0;
            end
          end else begin
            step_d   = step_q + STEP_W'(1);
            cnt_load = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (!req_on) begin
          state_d  = ST_AST_WAIT;
          step_d   = LAST_STEP;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end

      ST_AST_WAIT: begin
        if (req_on) begin
          if ((dom_q == ALL_UP) && ack_q) begin
            // Nothing re-asserted yet: turn straight back to UP.
            state_d = ST_UP;
            busy_d  = 1'b0;
          end else begin
            // Release again from the lowest held domain upward.
            state_d  = ST_REL_WAIT;
            cnt_load = 1'b1;
            if (dom_q == ALL_UP) begin
              step_d = LAST_STEP;
            end else if (step_released) begin
              step_d = step_q + STEP_W'(1);
            end else begin
              step_d = step_q;
            end
          end
        end else if (dom_q == '0) begin
          state_d = ST_DOWN;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_zero) begin
          dom_d = dom_q & ~step_mask;
          if (step_q == '0) begin
            if (!ack_q) begin
              state_d = ST_DOWN;
              busy_d  = 1'b0;
            end
          end else begin
            step_d   = step_q - STEP_W'(1);
            cnt_load = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_DOWN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DOWN;
      step_q  <= '0;
      dom_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dly_q   <= DLY_RST_V;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dom_q   <= dom_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dly_q   <= dly_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign dom_rst_n = dom_q;
  assign step_idx  = step_q;

endmodule : reset_domain_sequencer

// File: tb/tb_reset_domain_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_domain_sequencer
//   Directed latency scenarios followed by random req_on / cfg traffic. A
//   reference model, expressed as "number of released domains" plus a
//   countdown, pushes the expected outputs for every clock edge into a queue;
//   a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_reset_domain_sequencer;

  localparam int N_DOM   = 2;
  localparam int CNT_W   = 8;
  localparam int DLY_RST = 16;

  logic             clock;
  logic             reset_n;
  logic             req_on;
  logic             ack;
  logic             busy;
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_dly;
  logic [N_DOM-1:0] dom_rst_n;
  logic [2:0]       step_idx;

  typedef struct {
    logic [N_DOM-1:0] dom;
    logic             ack;
    logic             busy;
    logic [2:0]       step;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   req_at_edge = 1'b0;
  bit   edge_seen   = 1'b0;

  reset_domain_sequencer #(
    .N_DOM   (N_DOM),
    .CNT_W   (CNT_W),
    .DLY_RST (DLY_RST)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_on    (req_on),
    .ack       (ack),
    .busy      (busy),
    .cfg_we    (cfg_we),
    .cfg_dly   (cfg_dly),
    .dom_rst_n (dom_rst_n),
    .step_idx  (step_idx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the domains are described by how many are released
  // (m_up); a sequence runs toward N_DOM or 0 with m_rem cycles left before
  // the next step.
  initial begin
    int   m_up;
    int   m_rem;
    int   m_dly;
    int   rv;
    int   tgt;
    bit   m_ack;
    bit   m_act;
    bit   m_dir;
    bit   r;
    exp_t e;
    m_up = 0; m_rem = 0; m_dly = DLY_RST; m_ack = 0; m_act = 0; m_dir = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_up = 0; m_rem = 0; m_dly = DLY_RST; m_ack = 0; m_act = 0; m_dir = 0;
        sb_q.delete();
        edge_seen = 1'b0;
      end else begin
        r  = req_on;
        rv = cfg_we ? int'(cfg_dly) : m_dly;
        if (!m_act) begin
          if (r != m_ack) begin
            m_act = 1; m_dir = r; m_rem = rv;
          end
        end else if (r != m_dir) begin
          tgt = r ? N_DOM : 0;
          if (m_up == tgt && m_ack == r) m_act = 0;
          else begin m_dir = r; m_rem = rv; end
        end else begin
          tgt = m_dir ? N_DOM : 0;
          if (m_up == tgt) begin
            m_act = 0; m_ack = m_dir;
          end else if (m_rem == 0) begin
            m_up = m_dir ? m_up + 1 : m_up - 1;
            if (m_up == tgt && m_ack == m_dir) m_act = 0;
            else m_rem = rv;
          end else begin
            m_rem--;
          end
        end
        if (cfg_we) m_dly = int'(cfg_dly);
        e.dom  = N_DOM'((1 << m_up) - 1);
        e.ack  = m_ack;
        e.busy = m_act;
        if (!m_act)     e.step = m_ack ? 3'(N_DOM - 1) : 3'd0;
        else if (m_dir) e.step = (m_up == N_DOM) ? 3'(N_DOM - 1) : 3'(m_up);
        else            e.step = (m_up == 0) ? 3'd0 : 3'(m_up - 1);
        sb_q.push_back(e);
        req_at_edge = r;
        edge_seen   = 1'b1;
      end
    end
  end

  // Monitor: compares away from the active edge.
  initial begin
    exp_t             e;
    logic [N_DOM-1:0] inc;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("sb_dom",  32'(dom_rst_n), 32'(e.dom));
          check("sb_ack",  32'(ack),       32'(e.ack));
          check("sb_busy", 32'(busy),      32'(e.busy));
          check("sb_step", 32'(step_idx),  32'(e.step));
        end
        inc = dom_rst_n + N_DOM'(1);
        check("thermometer", 32'((inc & dom_rst_n) == '0), 32'd1);
        if (edge_seen && busy === 1'b0)
          check("ack_eq_req_idle", 32'(ack), 32'(req_at_edge));
      end
    end
  end

  // Steps edges until dom/ack reach the given values; reports the cycle.
  task automatic wait_out(input logic [N_DOM-1:0] dom_v, input logic ack_v, input int max_c,
                          output int at, output logic [N_DOM-1:0] seen);
    at   = -1;
    seen = '0;
    for (int i = 0; i < max_c; i++) begin
      @(posedge clock); #1;
      cyc++;
      seen = seen | dom_rst_n;
      if (dom_rst_n === dom_v && ack === ack_v) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic origin();
    @(posedge clock); #1;
    cyc = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  initial begin
    int               at;
    logic [N_DOM-1:0] seen;
    reset_n = 1'b0; req_on = 1'b0; cfg_we = 1'b0; cfg_dly = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_dom",  32'(dom_rst_n), 32'd0);
    check("rst_ack",  32'(ack),       32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_step", 32'(step_idx),  32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Release with reset delay of 16.
    req_on = 1'b1; origin();
    wait_out(2'b01, 1'b0, 40, at, seen); check("t1_bit0_at", at, 17);
    wait_out(2'b11, 1'b0, 40, at, seen); check("t1_bit1_at", at, 34);
    wait_out(2'b11, 1'b1, 10, at, seen); check("t1_ack_at",  at, 35);
    check("t1_busy_done", 32'(busy), 32'd0);

    // Re-assert from UP.
    req_on = 1'b0; origin();
    wait_out(2'b01, 1'b1, 40, at, seen); check("t2_bit1_clr_at", at, 17);
    wait_out(2'b00, 1'b1, 40, at, seen); check("t2_bit0_clr_at", at, 34);
    wait_out(2'b00, 1'b0, 10, at, seen); check("t2_ack_fall_at", at, 35);

    // Reversal 5 cycles after domain 0 released.
    req_on = 1'b1; origin();
    wait_out(2'b01, 1'b0, 40, at, seen); check("t3_bit0_at", at, 17);
    idle_cycles(4);
    req_on = 1'b0;
    wait_out(2'b00, 1'b0, 40, at, seen); check("t3_bit0_clr_at", at, 39);
    check("t3_bit1_never", 32'(seen[1]), 32'd0);
    check("t3_busy_fell",  32'(busy),    32'd0);

    // Zero delay: one domain per cycle.
    cfg_dly = 8'd0; cfg_we = 1'b1;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    req_on = 1'b1; origin();
    wait_out(2'b01, 1'b0, 10, at, seen); check("t4_d0_bit0_at", at, 1);
    wait_out(2'b11, 1'b0, 10, at, seen); check("t4_d0_bit1_at", at, 2);
    wait_out(2'b11, 1'b1, 10, at, seen); check("t4_d0_ack_at",  at, 3);
    req_on = 1'b0; origin();
    wait_out(2'b00, 1'b0, 10, at, seen); check("t4_d0_down_at", at, 3);

    // Delay rewritten mid-countdown: current step keeps its count.
    cfg_dly = 8'd10; cfg_we = 1'b1;
    @(posedge clock); #1;
    cfg_we = 1'b0;
    req_on = 1'b1; origin();
    idle_cycles(3);
    cfg_dly = 8'd3; cfg_we = 1'b1;
    idle_cycles(1);
    cfg_we = 1'b0;
    wait_out(2'b01, 1'b0, 30, at, seen); check("t4_cfg_bit0_at", at, 11);
    wait_out(2'b11, 1'b0, 30, at, seen); check("t4_cfg_bit1_at", at, 15);
    wait_out(2'b11, 1'b1, 10, at, seen); check("t4_cfg_ack_at",  at, 16);

    // Reset while UP: outputs clear at once, delay returns to 16.
    reset_n = 1'b0; req_on = 1'b0;
    #1;
    check("t5_dom",  32'(dom_rst_n), 32'd0);
    check("t5_ack",  32'(ack),       32'd0);
    check("t5_busy", 32'(busy),      32'd0);
    check("t5_step", 32'(step_idx),  32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    req_on = 1'b1; origin();
    wait_out(2'b01, 1'b0, 40, at, seen); check("t5_dly_reset_bit0_at", at, 17);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if ($urandom_range(0, 29) == 0) req_on = ~req_on;
      cfg_we  = ($urandom_range(0, 49) == 0);
      cfg_dly = CNT_W'($urandom_range(0, 6));
    end
    cfg_we = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reset_domain_sequencer
